// File: rtl/alu_tx_pkg.sv
// Shared definitions for the ALU result serial transmitter.
// Optional feature macro: ALU_TX_PARITY_EN (even parity bit after the data bits).
package alu_tx_pkg;

  // Transmitter FSM states; PARITY is only reachable when ALU_TX_PARITY_EN is defined
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Every frame carries a full byte; narrower ALU results are zero-extended
  localparam int FRAME_BITS = 8;
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

  // Line levels for framing and for the idle line
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: emits a one-cycle tick on the last cycle of each bit period.
// The clear input restarts the period so every state begins a fresh full bit.
module baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  // Tick depends only on the count so it never loops back through the FSM's clear
  assign tick = (count == LAST_COUNT);

  // Count cycles within a bit, wrapping on the tick or restarting on clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/alu_result_tx.sv
// Serial transmitter for ALU results: start bit, 8 data bits LSB first,
// optional even parity bit, stop bit; each bit lasts CLKS_PER_BIT cycles.
// Optional feature macro: ALU_TX_PARITY_EN.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int NB_DATA      = 6,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  tx_state_t state;
  tx_state_t next_state;
  logic      tick;
  logic      bit_clear;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [2:0] bit_idx;
  logic       accept;
`ifdef ALU_TX_PARITY_EN
  logic       parity_bit;
`endif

  assign accept = (state == IDLE) && i_valid;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clock(clock),
    .reset(i_reset),
    .clear(bit_clear),
    .tick (tick)
  );

  // State register; reset drops straight back to an idle line
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; the period counter restarts on every state change
  always_comb begin
    next_state = state;
    o_tx       = IDLE_LEVEL;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_valid) next_state = START;
      end
      START: begin
        o_tx = START_LEVEL;
        if (tick) next_state = DATA;
      end
      DATA: begin
        o_tx = shift_reg[0];
`ifdef ALU_TX_PARITY_EN
        if (tick && (bit_idx == LAST_BIT)) next_state = PARITY;
`else
        if (tick && (bit_idx == LAST_BIT)) next_state = STOP;
`endif
      end
`ifdef ALU_TX_PARITY_EN
      PARITY: begin
        o_tx = parity_bit;
        if (tick) next_state = STOP;
      end
`endif
      STOP: begin
        o_tx = STOP_LEVEL;
        if (tick) begin
          o_done     = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    bit_clear = (next_state != state) || (state == IDLE);
  end

  // Frame datapath: latch the zero-extended result on acceptance, shift out one bit per period
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      shift_reg  <= '0;
      bit_idx    <= '0;
`ifdef ALU_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg  <= FRAME_BITS'(i_data);
      bit_idx    <= '0;
`ifdef ALU_TX_PARITY_EN
      parity_bit <= ^i_data;
`endif
    end else if ((state == DATA) && tick) begin
      shift_reg <= shift_reg >> 1;
      bit_idx   <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// Self-checking bench for alu_result_tx with CLKS_PER_BIT=4, NB_DATA=6.
// Honours ALU_TX_PARITY_EN when the same macro is defined for the build.
module tb_alu_result_tx;

  localparam int NB_DATA      = 6;
  localparam int CLKS_PER_BIT = 4;
`ifdef ALU_TX_PARITY_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_LEN * CLKS_PER_BIT;

  logic clock = 1'b0;
  logic i_reset;
  logic [NB_DATA-1:0] i_data;
  logic i_valid;
  logic o_tx;
  logic o_busy;
  logic o_done;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  alu_result_tx #(
    .NB_DATA(NB_DATA),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_tx   (o_tx),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  // Reference: {tx, busy, done} expected on cycle k (1-based from start bit) of a frame
  function automatic logic [2:0] frame_expect(input logic [NB_DATA-1:0] d, input int k);
    logic [7:0] d8;
    int b;
    logic tx;
    d8 = {2'b00, d};
    b  = (k - 1) / CLKS_PER_BIT;
    if (b == 0)                  tx = 1'b0;
    else if (b <= 8)             tx = d8[b-1];
    else if (b == FRAME_LEN - 1) tx = 1'b1;
    else                         tx = ^d8;
    return {tx, 1'b1, (k == FRAME_CYCLES)};
  endfunction

  // Check the line is idle: tx high, not busy, no done
  task automatic check_idle(input string name);
    checks++;
    if ({o_tx, o_busy, o_done} !== 3'b100)
      $display("[TB] FAIL %s: got tx/busy/done=%b expected 100", name, {o_tx, o_busy, o_done});
    else
      passed++;
  endtask

  // Request a frame and check every cycle of it; poke>0 injects a mid-frame request of 6'h3f
  task automatic run_frame(input logic [NB_DATA-1:0] d, input string name,
                           input bit hold, input int poke, input int stop_at);
    logic [2:0] exp_v;
    @(negedge clock);
    i_data  = d;
    i_valid = 1'b1;
    check_idle({name, "_idle"});
    for (int k = 1; k <= stop_at; k++) begin
      @(negedge clock);
      if (!hold && k == 1) i_valid = 1'b0;
      if (poke > 0 && k == poke) begin
        i_valid = 1'b1;
        i_data  = 6'h3f;
      end
      if (poke > 0 && k == poke + 1) i_valid = 1'b0;
      exp_v = frame_expect(d, k);
      checks++;
      if ({o_tx, o_busy, o_done} !== exp_v)
        $display("[TB] FAIL %s cycle %0d: got tx/busy/done=%b expected %b",
                 name, k, {o_tx, o_busy, o_done}, exp_v);
      else
        passed++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_data  = 6'h15;
    repeat (3) @(negedge clock);
    check_idle("reset_hold");
    i_reset = 1'b0;
    i_valid = 1'b0;
    @(negedge clock);
    check_idle("reset_release");
  endtask

  task automatic test_basic();
    run_frame(6'b000100, "basic", 1'b0, 0, FRAME_CYCLES);
    @(negedge clock);
    check_idle("basic_after");
  endtask

  task automatic test_parity_pattern();
    run_frame(6'b101011, "pattern", 1'b0, 0, FRAME_CYCLES);
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      run_frame(NB_DATA'($urandom_range(0, 63)), "random", 1'b0, 0, FRAME_CYCLES);
    end
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1;
    run_frame(6'b001111, "b2b_first", 1'b1, 0, FRAME_CYCLES);
    run_frame(6'b001111, "b2b_second", 1'b1, 0, FRAME_CYCLES);
    i_valid = 1'b0;
    @(negedge clock);
    check_idle("b2b_end_a");
    @(negedge clock);
    check_idle("b2b_end_b");
  endtask

  task automatic test_mid_reset();
    // Cycle 18 lies inside data bit 3 (cycles 17..20)
    run_frame(6'b000100, "midrst_pre", 1'b0, 0, 18);
    i_reset = 1'b1;
    #1;
    check_idle("midrst_same_cycle");
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      i_valid = 1'b1;
      i_data  = NB_DATA'($urandom_range(0, 63));
      check_idle("midrst_held");
    end
    @(negedge clock);
    i_reset = 1'b0;
    i_valid = 1'b0;
    check_idle("midrst_release");
    run_frame(6'b000100, "midrst_after", 1'b0, 0, FRAME_CYCLES);
  endtask

  task automatic test_mid_change();
    run_frame(6'b010010, "midchg", 1'b0, 10, FRAME_CYCLES);
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      check_idle("midchg_no_second");
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    test_reset();
    test_basic();
    test_parity_pattern();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_mid_change();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_tx.md
ALU_RESULT_TX -- requirements
Module: alu_result_tx

Interface
REQ-001 SHALL have parameter NB_DATA, default 6, width of the ALU result to send (1..8).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (>= 2).
REQ-003 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_data  input  NB_DATA  ALU result to transmit.
REQ-006 SHALL have port i_valid  input  1  send request, sampled only in IDLE.
REQ-007 SHALL have port o_tx  output  1  serial line, idle high.
REQ-008 SHALL have port o_busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port o_done  output  1  one-cycle pulse at end of frame.

Function
REQ-010 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE after reset.
REQ-011 SHALL, in IDLE with i_valid high, latch i_data zero-extended to 8 bits and enter START on the next edge.
REQ-012 SHALL drive o_tx low in START, data bits LSB first in DATA, and high in STOP.
REQ-013 SHALL hold each bit for exactly CLKS_PER_BIT cycles, counted by a bit-period counter cleared on each state entry.
REQ-014 SHALL count DATA bits 0..7 with a 3-bit index and leave DATA after bit 7 completes, with no wrap into a ninth bit.
REQ-015 SHALL assert o_busy in every state except IDLE, starting the cycle after acceptance.
REQ-016 SHALL pulse o_done for one cycle on the final cycle of STOP and return to IDLE on the next edge.
REQ-017 SHALL ignore i_valid while o_busy is high; i_data changes mid-frame SHALL NOT alter the frame.
REQ-018 SHALL accept a new request in the first IDLE cycle after o_done (back-to-back frames, one idle cycle between).
REQ-019 SHALL make the total frame length (10 bits without parity, 11 with) x CLKS_PER_BIT cycles from START entry to IDLE re-entry.

Reset
REQ-020 SHALL, on i_reset assertion at any time (including mid-frame), immediately force state IDLE, o_tx=1, o_busy=0, o_done=0, and clear the counters and shift register.
REQ-021 SHALL ignore i_valid while i_reset is high; after release, first acceptance SHALL occur at the first edge with i_valid high.

Configuration
REQ-022 SHALL use macro ALU_TX_PARITY_EN: when defined, PARITY state sends even parity (XOR of the 8 data bits) after DATA; when undefined, DATA goes directly to STOP and the PARITY state is not synthesized.

Structure
REQ-023 SHALL place the state encoding, frame data width (8), start/stop bit levels in a shared package alu_tx_pkg.
REQ-024 SHALL implement the bit-period counter as sub-module baud_tick (CLKS_PER_BIT parameter, clear input, one-cycle tick output).

Verification (CLKS_PER_BIT=4, NB_DATA=6)
REQ-025 SHALL verify: reset, then i_valid pulse with i_data=6'b000100 -> o_tx low 4 cycles, then 0,0,1,0,0,0,0,0 at 4 cycles each, stop high, o_done at cycle 40 (44 with parity).
REQ-026 SHALL verify: i_data=6'b101011 with ALU_TX_PARITY_EN -> data 1,1,0,1,0,1,0,0 then parity bit 0 (even), 11-bit frame.
REQ-027 SHALL verify: i_valid held high continuously with i_data=6'b001111 -> back-to-back frames, exactly one IDLE cycle between o_done and next start bit.
REQ-028 SHALL verify: i_reset asserted during DATA bit 3 -> o_tx=1, o_busy=0 in the same cycle, no o_done; next request produces a complete correct frame.
REQ-029 SHALL verify: i_valid pulse and i_data change to 6'b111111 mid-frame -> original frame unaffected, second request not accepted.
